tt_um_count_checker: RTL and testbench
======================================

Name: tt_um_count_checker

Overview:
- Receive-side companion to the 8-bit start/stop counter tile: it reads the counter value stream on ui_in and the stop flag that drives the counter on uio_in[0].
- Checks every cycle that the value either increments by 1 modulo 256, or holds when the stop flag was high.
- Acquires lock, counts mismatches and wrap-arounds, detects loss of lock, and reports results through a selectable output byte.

Parameters:
- LOCK_COUNT, 4, consecutive matching samples required to enter LOCKED (1..15).
- LOSS_LIMIT, 3, consecutive mismatches in LOCKED that force a return to ACQ (1..15).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  always 1; ignored.
- ui_in  input  8  observed counter value.
- uio_in  input  8  [0] hold (stop flag as fed to the counter); [1] clear; [3:2] output select; [7:4] unused.
- uo_out  output  8  selected readout byte.
- uio_out  output  8  [7:4] = {locked, lost, err_pulse, err_sat}; [3:0] = 0.
- uio_oe  output  8  constant 8'hF0.

Behaviour:
- Reset: asynchronous on rst_n low. Clears all of the following:
  - state = ACQ, s_valid = 0, s_val = 0, s_hold = 0
  - good_run = 0, bad_run = 0, err_cnt = 0 (16-bit), wrap_cnt = 0 (8-bit)
  - lost = 0, err_pulse = 0
  - Result: uo_out = 0 and uio_out = 0 during and right after reset.
- Sample register, every posedge: s_val <= ui_in, s_hold <= uio_in[0], s_valid <= 1.
- Prediction: exp = s_hold ? s_val : s_val + 1, computed modulo 256 (so 255 + 1 = 0). This matches the counter's one-cycle register latency.
- Compare: match = s_valid && (ui_in == exp). When s_valid = 0 (first cycle after reset), no compare occurs and all counters are unchanged.
- State ACQ:
  - match: good_run++; when good_run + 1 == LOCK_COUNT, go to LOCKED, clear good_run and bad_run.
  - mismatch: good_run = 0.
  - Errors are not counted in ACQ.
- State LOCKED:
  - match: bad_run = 0; if s_val == 255, s_hold == 0 and ui_in == 0, then wrap_cnt++ (wraps 255 -> 0).
  - mismatch: err_cnt++ saturating at 16'hFFFF; err_pulse = 1 for exactly the next cycle; bad_run++.
  - When bad_run + 1 == LOSS_LIMIT: go to ACQ, set lost = 1 (sticky), clear bad_run and good_run.
- err_sat = (err_cnt == 16'hFFFF).
- locked = (state == LOCKED).
- err_pulse is registered, so it is high in the cycle after the mismatched sample was presented.
- Clear (uio_in[1] = 1, sampled synchronously): err_cnt, wrap_cnt and lost all go to 0.
  - Clear wins over a same-cycle increment: the result is 0, not 1.
  - Clear does not affect state, good_run, bad_run or err_pulse.
- Output select uio_in[3:2], combinational mux of registered values:
  - 0: err_cnt[7:0]
  - 1: err_cnt[15:8]
  - 2: status {4'b0, err_sat, err_pulse, lost, locked}
  - 3: wrap_cnt
- Hold toggling does not by itself cause errors. A held value followed by an increment is legal.
- A reset asserted mid-operation returns to ACQ immediately and clears all counters.

Test Plan:
1. Reset, then ui_in = 0,1,2,3,4,5 on successive cycles with hold = 0 -> locked rises after the 5th value (LOCK_COUNT = 4 matches), err_cnt = 0, lost = 0.
2. While locked, drive 10,11,11 with hold = 1 on the cycle 11 is first sampled, then 12 with hold = 0 -> no err_pulse, err_cnt = 0.
3. While locked, inject one bad value (20,21,40,41) -> err_pulse high for one cycle, err_cnt = 1, locked remains 1; sel = 0 reads 8'h01.
4. While locked, inject 3 consecutive mismatches -> err_cnt = 3, locked = 0, lost = 1; sel = 2 reads 8'h02 (err_pulse has fallen by then); then 4 good increments -> locked = 1 with lost still 1.
5. Run 250..255,0,1 while locked -> wrap_cnt = 1 (sel = 3 reads 8'h01); assert clear in the same cycle as a mismatch -> err_cnt = 0, wrap_cnt = 0, lost = 0, locked unchanged.
6. Preload by forcing 65535 mismatch events (or force err_cnt = 16'hFFFE), then apply 2 more errors -> err_cnt holds at 16'hFFFF, err_sat = 1; assert rst_n low mid-stream -> all outputs 0 asynchronously, uio_oe remains 8'hF0.

Source files
------------

// File: rtl/tt_um_count_checker.sv
// Receive-side checker for the 8-bit start/stop counter tile: tracks the value
// stream, acquires lock, counts mismatches and wraps, and flags loss of lock.
module tt_um_count_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {
    ST_ACQ,
    ST_LOCKED
  } state_e;

  localparam logic [4:0] LOCK_TGT = 5'(LOCK_COUNT);
  localparam logic [4:0] LOSS_TGT = 5'(LOSS_LIMIT);

  state_e      state_q, state_d;
  logic        s_valid_q, s_valid_d;
  logic [7:0]  s_val_q, s_val_d;
  logic        s_hold_q, s_hold_d;
  logic [3:0]  good_run_q, good_run_d;
  logic [3:0]  bad_run_q, bad_run_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [7:0]  wrap_cnt_q, wrap_cnt_d;
  logic        lost_q, lost_d;
  logic        err_pulse_q, err_pulse_d;

  logic [7:0]  exp_val;
  logic        match;
  logic        hold_in, clear_in;
  logic [1:0]  sel;
  logic        locked, err_sat;
  logic        unused_ok;

  assign hold_in   = uio_in[0];
  assign clear_in  = uio_in[1];
  assign sel       = uio_in[3:2];
  assign unused_ok = ^{ena, uio_in[7:4]};

  // The counter registers its output, so the value seen now follows from the
  // previous sample and the stop flag that accompanied it.
  assign exp_val = s_hold_q ? s_val_q : s_val_q + 8'd1;
  assign match   = s_valid_q && (ui_in == exp_val);

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    s_valid_d   = 1'b1;
    s_val_d     = ui_in;
    s_hold_d    = hold_in;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    lost_d      = lost_q;
    err_pulse_d = 1'b0;

    if (s_valid_q) begin
      case (state_q)
        ST_ACQ: begin
          if (match) begin
            if ({1'b0, good_run_q} + 5'd1 == LOCK_TGT) begin
              state_d    = ST_LOCKED;
              good_run_d = '0;
              bad_run_d  = '0;
            end else begin
              good_run_d = good_run_q + 4'd1;
            end
          end else begin
            good_run_d = '0;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            bad_run_d = '0;
            if (s_val_q == 8'hFF && !s_hold_q && ui_in == 8'h00) begin
              wrap_cnt_d = wrap_cnt_q + 8'd1;
            end
          end else begin
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
            err_pulse_d = 1'b1;
            if ({1'b0, bad_run_q} + 5'd1 == LOSS_TGT) begin
              state_d    = ST_ACQ;
              lost_d     = 1'b1;
              bad_run_d  = '0;
              good_run_d = '0;
            end else begin
              bad_run_d = bad_run_q + 4'd1;
            end
          end
        end
        default: state_d = ST_ACQ;
      endcase
    end

    // Clear overrides any same-cycle increment or loss event.
    if (clear_in) begin
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
      lost_d     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACQ;
      s_valid_q   <= 1'b0;
      s_val_q     <= '0;
      s_hold_q    <= 1'b0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      lost_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_valid_q   <= s_valid_d;
      s_val_q     <= s_val_d;
      s_hold_q    <= s_hold_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      lost_q      <= lost_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked  = (state_q == ST_LOCKED);
  assign err_sat = (err_cnt_q == 16'hFFFF);

  always_comb begin
    uo_out = '0;
    case (sel)
      2'd0: uo_out = err_cnt_q[7:0];
      2'd1: uo_out = err_cnt_q[15:8];
      2'd2: uo_out = {4'b0000, err_sat, err_pulse_q, lost_q, locked};
      2'd3: uo_out = wrap_cnt_q;
      default: uo_out = '0;
    endcase
  end

  assign uio_out = {locked, lost_q, err_pulse_q, err_sat, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Self-checking bench for tt_um_count_checker: directed scenarios followed by
// a randomized counter stream compared against a behavioural model.
module tb_tt_um_count_checker;

  localparam int LOCK_COUNT = 4;
  localparam int LOSS_LIMIT = 3;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, kept as plain integers.
  bit m_valid;
  int m_prev;
  bit m_prev_hold;
  bit m_locked;
  int m_good;
  int m_bad;
  int m_err;
  int m_wrap;
  bit m_lost;
  bit m_pulse;

  tt_um_count_checker #(
    .LOCK_COUNT(LOCK_COUNT),
    .LOSS_LIMIT(LOSS_LIMIT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 0; m_prev = 0; m_prev_hold = 0; m_locked = 0;
    m_good = 0; m_bad = 0; m_err = 0; m_wrap = 0; m_lost = 0; m_pulse = 0;
  endtask

  task automatic model_step(input int v, input bit hold, input bit clr);
    int  expect_v;
    bit  ok;
    m_pulse = 0;
    if (m_valid) begin
      expect_v = m_prev_hold ? m_prev : (m_prev + 1) % 256;
      ok = (v == expect_v);
      if (!m_locked) begin
        if (ok) begin
          m_good++;
          if (m_good == LOCK_COUNT) begin
            m_locked = 1; m_good = 0; m_bad = 0;
          end
        end else begin
          m_good = 0;
        end
      end else begin
        if (ok) begin
          m_bad = 0;
          if (m_prev == 255 && v == 0) m_wrap = (m_wrap + 1) % 256;
        end else begin
          if (m_err < 65535) m_err++;
          m_pulse = 1;
          m_bad++;
          if (m_bad == LOSS_LIMIT) begin
            m_locked = 0; m_lost = 1; m_bad = 0; m_good = 0;
          end
        end
      end
    end
    if (clr) begin
      m_err = 0; m_wrap = 0; m_lost = 0;
    end
    m_prev = v; m_prev_hold = hold; m_valid = 1;
  endtask

  function automatic logic [7:0] model_uo(input logic [1:0] s);
    case (s)
      2'd0: return 8'(m_err % 256);
      2'd1: return 8'(m_err / 256);
      2'd2: return {4'b0000, (m_err == 65535), m_pulse, m_lost, m_locked};
      default: return 8'(m_wrap);
    endcase
  endfunction

  function automatic logic [7:0] model_uio();
    return {m_locked, m_lost, m_pulse, (m_err == 65535), 4'b0000};
  endfunction

  // Present one sample across a rising edge, then settle 1 time unit past it.
  task automatic drive(input int v, input bit hold, input bit clr);
    ui_in     = 8'(v);
    uio_in[0] = hold;
    uio_in[1] = clr;
    @(posedge clk);
    model_step(v, hold, clr);
    #1;
    uio_in[1] = 1'b0;
  endtask

  task automatic read_sel(input logic [1:0] s, output logic [7:0] val);
    uio_in[3:2] = s;
    #1;
    val = uo_out;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      read_sel(2'(s), v);
      checks++;
      if (v !== 8'h00) begin
        errors++; $display("FAIL reset_uo sel=%0d got=%h want=00", s, v);
      end
    end
    checks++;
    if (uio_out !== 8'h00) begin
      errors++; $display("FAIL reset_uio got=%h want=00", uio_out);
    end
    checks++;
    if (uio_oe !== 8'hF0) begin
      errors++; $display("FAIL reset_oe got=%h want=F0", uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (uio_out !== 8'h00) begin
      errors++; $display("FAIL post_reset_uio got=%h want=00", uio_out);
    end
  endtask

  task automatic test_lock();
    logic [7:0] v;
    for (int i = 0; i <= 5; i++) begin
      drive(i, 0, 0);
      if (i == 3) begin
        checks++;
        if (uio_out[7] !== 1'b0) begin
          errors++; $display("FAIL lock_early got=%b want=0", uio_out[7]);
        end
      end
      if (i == 4) begin
        checks++;
        if (uio_out[7] !== 1'b1) begin
          errors++; $display("FAIL lock_rise got=%b want=1", uio_out[7]);
        end
      end
    end
    read_sel(2'd0, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL lock_err got=%h want=00", v);
    end
    checks++;
    if (uio_out[6] !== 1'b0) begin
      errors++; $display("FAIL lock_lost got=%b want=0", uio_out[6]);
    end
  endtask

  task automatic test_hold();
    logic [7:0] v;
    for (int i = 6; i <= 9; i++) drive(i, 0, 0);
    drive(10, 0, 0);
    drive(11, 1, 0);
    checks++;
    if (uio_out[5] !== 1'b0) begin
      errors++; $display("FAIL hold_pulse_a got=%b want=0", uio_out[5]);
    end
    drive(11, 0, 0);
    checks++;
    if (uio_out[5] !== 1'b0) begin
      errors++; $display("FAIL hold_pulse_b got=%b want=0", uio_out[5]);
    end
    drive(12, 0, 0);
    checks++;
    if (uio_out[5] !== 1'b0) begin
      errors++; $display("FAIL hold_pulse_c got=%b want=0", uio_out[5]);
    end
    read_sel(2'd0, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL hold_err got=%h want=00", v);
    end
    checks++;
    if (uio_out[7] !== 1'b1) begin
      errors++; $display("FAIL hold_locked got=%b want=1", uio_out[7]);
    end
  endtask

  task automatic test_single_error();
    logic [7:0] v;
    for (int i = 13; i <= 21; i++) drive(i, 0, 0);
    drive(40, 0, 0);
    checks++;
    if (uio_out[5] !== 1'b1) begin
      errors++; $display("FAIL single_pulse_hi got=%b want=1", uio_out[5]);
    end
    drive(41, 0, 0);
    checks++;
    if (uio_out[5] !== 1'b0) begin
      errors++; $display("FAIL single_pulse_lo got=%b want=0", uio_out[5]);
    end
    read_sel(2'd0, v);
    checks++;
    if (v !== 8'h01) begin
      errors++; $display("FAIL single_err got=%h want=01", v);
    end
    checks++;
    if (uio_out[7] !== 1'b1) begin
      errors++; $display("FAIL single_locked got=%b want=1", uio_out[7]);
    end
  endtask

  task automatic test_loss();
    logic [7:0] v;
    drive(42, 0, 1);
    read_sel(2'd0, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL loss_clear got=%h want=00", v);
    end
    drive(100, 0, 0);
    drive(200, 0, 0);
    checks++;
    if (uio_out[7] !== 1'b1) begin
      errors++; $display("FAIL loss_still_locked got=%b want=1", uio_out[7]);
    end
    drive(50, 0, 0);
    checks++;
    if (uio_out[7:6] !== 2'b01) begin
      errors++; $display("FAIL loss_drop got=%b want=01", uio_out[7:6]);
    end
    read_sel(2'd0, v);
    checks++;
    if (v !== 8'h03) begin
      errors++; $display("FAIL loss_err got=%h want=03", v);
    end
    drive(51, 0, 0);
    read_sel(2'd2, v);
    checks++;
    if (v !== 8'h02) begin
      errors++; $display("FAIL loss_status got=%h want=02", v);
    end
    drive(52, 0, 0);
    drive(53, 0, 0);
    checks++;
    if (uio_out[7] !== 1'b0) begin
      errors++; $display("FAIL loss_relock_early got=%b want=0", uio_out[7]);
    end
    drive(54, 0, 0);
    read_sel(2'd2, v);
    checks++;
    if (v !== 8'h03) begin
      errors++; $display("FAIL loss_relock got=%h want=03", v);
    end
  endtask

  task automatic test_wrap_clear();
    logic [7:0] v;
    for (int i = 55; i <= 255; i++) drive(i, 0, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    read_sel(2'd3, v);
    checks++;
    if (v !== 8'h01) begin
      errors++; $display("FAIL wrap_cnt got=%h want=01", v);
    end
    drive(77, 0, 1);
    read_sel(2'd0, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL clear_err got=%h want=00", v);
    end
    read_sel(2'd3, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL clear_wrap got=%h want=00", v);
    end
    checks++;
    if (uio_out[7:5] !== 3'b101) begin
      errors++; $display("FAIL clear_flags got=%b want=101", uio_out[7:5]);
    end
    drive(78, 0, 0);
  endtask

  task automatic test_saturation();
    logic [7:0] v;
    force dut.err_cnt_q = 16'hFFFE;
    #1;
    release dut.err_cnt_q;
    m_err = 65534;
    read_sel(2'd1, v);
    checks++;
    if (v !== 8'hFF) begin
      errors++; $display("FAIL sat_preload_hi got=%h want=FF", v);
    end
    drive(200, 0, 0);
    checks++;
    if (uio_out[4] !== 1'b1) begin
      errors++; $display("FAIL sat_flag got=%b want=1", uio_out[4]);
    end
    drive(201, 0, 0);
    drive(5, 0, 0);
    read_sel(2'd0, v);
    checks++;
    if (v !== 8'hFF) begin
      errors++; $display("FAIL sat_hold_lo got=%h want=FF", v);
    end
    read_sel(2'd2, v);
    checks++;
    if (v !== 8'h0D) begin
      errors++; $display("FAIL sat_status got=%h want=0D", v);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int s = 0; s < 4; s++) begin
      read_sel(2'(s), v);
      checks++;
      if (v !== 8'h00) begin
        errors++; $display("FAIL async_reset_uo sel=%0d got=%h want=00", s, v);
      end
    end
    checks++;
    if (uio_out !== 8'h00 || uio_oe !== 8'hF0) begin
      errors++; $display("FAIL async_reset_uio got=%h/%h want=00/F0", uio_out, uio_oe);
    end
  endtask

  task automatic test_random();
    int prev_v;
    bit prev_h;
    int v;
    bit h;
    bit c;
    logic [1:0] s;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    prev_v = $urandom_range(0, 255);
    prev_h = 0;
    for (int n = 0; n < 3000; n++) begin
      v = prev_h ? prev_v : (prev_v + 1) % 256;
      if ($urandom_range(0, 99) < 7) v = $urandom_range(0, 255);
      h = ($urandom_range(0, 99) < 25);
      c = ($urandom_range(0, 99) < 2);
      s = 2'($urandom_range(0, 3));
      uio_in[3:2] = s;
      drive(v, h, c);
      checks++;
      if (uo_out !== model_uo(s) || uio_out !== model_uio() || uio_oe !== 8'hF0) begin
        errors++;
        $display("FAIL random n=%0d sel=%0d got=%h/%h/%h want=%h/%h/F0",
                 n, s, uo_out, uio_out, uio_oe, model_uo(s), model_uio());
      end
      prev_v = v;
      prev_h = h;
    end
  endtask

  initial begin
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'hA0;
    test_reset();
    test_lock();
    test_hold();
    test_single_error();
    test_loss();
    test_wrap_clear();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
